// File: rtl/gf180mcu_fd_sc_mcu7t5v0__arb_pkg.sv
// Shared definitions for the 3-way round-robin arbiter: FSM states, owner
// encodings and the cyclic requester-index successor.
package gf180mcu_fd_sc_mcu7t5v0__arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_R1   = 2'd1;
  localparam logic [1:0] OWNER_R2   = 2'd2;
  localparam logic [1:0] OWNER_R3   = 2'd3;

  // (idx mod 3) + 1: the next requester after idx in cyclic order 1->2->3->1.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    case (idx)
      OWNER_R1: rr_next = OWNER_R2;
      OWNER_R2: rr_next = OWNER_R3;
      default:  rr_next = OWNER_R1;
    endcase
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrpick3.sv
// Combinational round-robin winner select: searches from the requester after
// PTR, cyclically, and returns the first active index (0 when none requests).
module gf180mcu_fd_sc_mcu7t5v0__rrpick3
  import gf180mcu_fd_sc_mcu7t5v0__arb_pkg::*;
(
  input  logic       R1,
  input  logic       R2,
  input  logic       R3,
  input  logic [1:0] PTR,
  output logic [1:0] WIN
);

  logic [3:0] req;
  logic [1:0] cand;

  assign req = {R3, R2, R1, 1'b0};

  always_comb begin
    WIN  = OWNER_NONE;
    cand = rr_next(PTR);
    for (int unsigned i = 0; i < 3; i++) begin
      if (WIN == OWNER_NONE && req[cand]) WIN = cand;
      cand = rr_next(cand);
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__arb3_1.sv
// Three-requester round-robin arbiter with hold-limit preemption and a
// one-cycle dead gap between owners; all outputs come straight from flops.
module gf180mcu_fd_sc_mcu7t5v0__arb3_1
  import gf180mcu_fd_sc_mcu7t5v0__arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       R1,
  input  logic       R2,
  input  logic       R3,
  input  logic       DONE,
  output logic       G1,
  output logic       G2,
  output logic       G3,
  output logic [1:0] OWNER,
  output logic       BUSY
);

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  arb_state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] owner_q, owner_d;
  logic [3:0] hold_q, hold_d;
  logic [2:0] g_q, g_d;
  logic       busy_q;
  logic [1:0] pick;
  logic [3:0] req;
  logic       owner_req;
  logic       others_req;
  logic       own_exit;

  gf180mcu_fd_sc_mcu7t5v0__rrpick3 u_pick (
    .R1  (R1),
    .R2  (R2),
    .R3  (R3),
    .PTR (ptr_q),
    .WIN (pick)
  );

  assign req        = {R3, R2, R1, 1'b0};
  assign owner_req  = req[owner_q];
  assign others_req = |(req & ~(4'd1 << owner_q));
  assign own_exit   = DONE || !owner_req || !EN ||
                      (hold_q == HOLD_LIM && others_req);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    case (state_q)
      ST_OWN: begin
        if (own_exit) begin
          state_d = ST_GAP;
          owner_d = OWNER_NONE;
          hold_d  = '0;
        end else if (hold_q != HOLD_LIM) begin
          hold_d = hold_q + 4'd1;
        end
      end
      // IDLE and GAP arbitrate identically; DONE plays no part here.
      default: begin
        if (EN && pick != OWNER_NONE) begin
          state_d = ST_OWN;
          owner_d = pick;
          ptr_d   = pick;
          hold_d  = 4'd1;
        end else begin
          state_d = ST_IDLE;
          owner_d = OWNER_NONE;
          hold_d  = '0;
        end
      end
    endcase
  end

  always_comb begin
    case (owner_d)
      OWNER_R1: g_d = 3'b001;
      OWNER_R2: g_d = 3'b010;
      OWNER_R3: g_d = 3'b100;
      default:  g_d = 3'b000;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ptr_q   <= OWNER_R3;
      owner_q <= OWNER_NONE;
      hold_q  <= '0;
      g_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      g_q     <= g_d;
      busy_q  <= |g_d;
    end
  end

  assign G1    = g_q[0];
  assign G2    = g_q[1];
  assign G3    = g_q[2];
  assign OWNER = owner_q;
  assign BUSY  = busy_q;

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__arb3_1.md
GF180MCU_FD_SC_MCU7T5V0__ARB3_1 -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__arb3_1

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the clock port is CLK and the reset port is RST.
REQ-002 Parameter HOLD_MAX, default 8: the number of consecutive grant cycles after which the owner is preempted if another requester is pending; the legal range is 1..15.
REQ-003 Port CLK, input, 1 bit: the rising-edge clock.
REQ-004 Port RST, input, 1 bit: asynchronous active-high reset.
REQ-005 Port EN, input, 1 bit: global arbitration enable.
REQ-006 Ports R1, R2, R3, input, 1 bit each: requests from requesters 1..3.
REQ-007 Port DONE, input, 1 bit: the current owner releases the resource.
REQ-008 Ports G1, G2, G3, output, 1 bit each: grants, registered, one-hot or all-zero.
REQ-009 Port OWNER, output, 2 bits: 0 means no owner; 1..3 is the index of the granted requester.
REQ-010 Port BUSY, output, 1 bit: high whenever any grant is high.

Function
REQ-011 The state machine SHALL have three states:
- IDLE: no owner.
- OWN: one grant high.
- GAP: a single dead cycle between owners.
REQ-012 Arbitration SHALL happen in IDLE and in GAP: if EN=1 and any Rn=1 at a rising edge, the state becomes OWN at that edge with exactly one Gn high; grant latency is 1 cycle from request sampling.
REQ-013 Selection SHALL be round-robin: the search starts at (PTR mod 3)+1 and proceeds cyclically, where PTR is the last owner index; the first requester found with Rn=1 wins.
REQ-014 PTR SHALL update to the owner index on every transition into OWN.
REQ-015 A hold counter (4 bits) SHALL behave as follows:
- loads 1 on entry to OWN;
- increments each OWN cycle;
- saturates at HOLD_MAX.
REQ-016 OWN SHALL exit to GAP at an edge where any of these is true:
- DONE=1;
- the owner's Rn=0;
- EN=0;
- hold counter == HOLD_MAX and any other Rn=1.
REQ-017 When the hold counter == HOLD_MAX and no other requester is pending, the owner SHALL keep the grant indefinitely.
REQ-018 Simultaneous exit conditions SHALL produce a single exit to GAP with no difference in behaviour.
REQ-019 In GAP all grants SHALL be 0 for exactly one cycle; the next state is OWN if EN=1 and any Rn=1, otherwise IDLE.
REQ-020 DONE SHALL be ignored in IDLE and in GAP.
REQ-021 EN=0 in IDLE or GAP SHALL hold the block in IDLE with no grants.
REQ-022 G1..G3, OWNER and BUSY SHALL be registered outputs with no combinational input-to-output path.
REQ-023 At most one Gn SHALL be high in any cycle, and OWNER SHALL always equal the index of the high Gn, or 0.

Reset
REQ-024 While RST=1, independent of CLK, the block SHALL immediately force:
- G1..G3 = 0, OWNER = 0, BUSY = 0;
- state = IDLE, PTR = 3, hold counter = 0.
REQ-025 An assertion of RST during OWN SHALL drop the grant in the same cycle, without passing through GAP.
REQ-026 After RST deasserts, the first arbitration SHALL favour R1 (because PTR = 3).

Structure
REQ-027 The state enumeration (IDLE, OWN, GAP) and the OWNER encoding constants SHALL reside in the shared package gf180mcu_fd_sc_mcu7t5v0__arb_pkg.
REQ-028 Round-robin selection SHALL be a combinational sub-module gf180mcu_fd_sc_mcu7t5v0__rrpick3, with inputs R1..R3 and PTR and output the winner index (0 if none).
REQ-029 The top level SHALL contain only the state register, PTR, the hold counter and the output registers.

Verification
REQ-030 Scenario "reset arbitration": after reset with EN=1 and R1=R2=R3=1 sampled at edge 0 -> G1=1 and OWNER=1 after edge 0; DONE pulse -> one GAP cycle with grants 0, then G2=1; next release -> GAP, then G3=1; next release -> GAP, then G1=1.
REQ-031 Scenario "preemption": with HOLD_MAX=4, R1 and R2 held high -> G1 high for exactly 4 cycles, GAP for 1 cycle, then G2 high for 4 cycles.
REQ-032 Scenario "sole requester": with only R3 high for 20 cycles and HOLD_MAX=8 -> G3 stays high for all 20 cycles; R3 low -> GAP, then IDLE with BUSY=0.
REQ-033 Scenario "EN drop": EN drops while G2=1 -> GAP, then IDLE while EN=0 and requests are pending; EN returns -> grant 1 cycle later, starting the search at R3.
REQ-034 Scenario "reset mid-grant": RST asserted mid-cycle while G1=1 -> G1, OWNER and BUSY go to 0 before the next edge; after release, R2 and R1 both high -> G1 wins.
REQ-035 Scenario "concurrent checks": random stimulus over 10k cycles -> at most one Gn high at any time, OWNER consistent with the grants, and every OWN-to-OWN handover separated by exactly one GAP cycle.
